// File: rtl/input_debounce_pkg.sv
// Shared constants, vector types and helpers for the input debouncer.
// Holds the button/pin counts and the default timing parameters.
package input_debounce_pkg;

   localparam int unsigned N_BTN = 4;
   localparam int unsigned N_PIN = 7;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 15000;
   localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

   typedef logic [N_BTN-1:0] btn_vec_t;
   typedef logic [N_PIN-1:0] pin_vec_t;

   // Which level transitions a debounce cell reports as a pulse.
   typedef enum logic {
      EDGE_RISE = 1'b0,
      EDGE_ANY  = 1'b1
   } edge_mode_e;

   function automatic logic multi_hot(input btn_vec_t v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < int'(N_BTN); i++) begin
         n = n + int'(v[i]);
      end
      return n > 1;
   endfunction

   function automatic int unsigned max_u(input int unsigned a,
                                         input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/input_debounce_cell.sv
// debounce_cell: one-bit 2-flop synchronizer, stability counter,
// debounced level and edge pulse. Ports: clock, reset_n, raw in;
// level (registered), level_nxt (next level), pulse (registered edge).
module debounce_cell
   import input_debounce_pkg::*;
#(
   parameter int unsigned CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter edge_mode_e  MODE   = EDGE_RISE
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic level_nxt,
   output logic pulse
);

   localparam int unsigned CW = $clog2(CYCLES + 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          pulse_q, pulse_d;

   always_comb begin
      sync_d  = {sync_q[0], raw};
      cnt_d   = '0;
      level_d = level_q;
      // Counter only runs while the synced input disagrees with the
      // accepted level; any agreeing cycle restarts it from zero.
      if (sync_q[1] != level_q) begin
         if (cnt_q == CW'(CYCLES - 1)) begin
            level_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      if (MODE == EDGE_ANY) begin
         pulse_d = level_d ^ level_q;
      end else begin
         pulse_d = level_d & ~level_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
      end
   end

   assign level     = level_q;
   assign level_nxt = level_d;
   assign pulse     = pulse_q;

endmodule

// File: rtl/input_debounce.sv
// input_debounce: debounces 4 buttons and 7 slide switches; press and
// change pulses, multi-button flag. Optional auto-repeat of button
// presses is enabled by defining DEBOUNCE_AUTOREPEAT_EN.
module input_debounce
   import input_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_PIN-1:0] pins_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_PIN-1:0] pins_level,
   output logic [N_PIN-1:0] pins_change,
   output logic             btn_multi
);

   btn_vec_t btn_nxt;
   btn_vec_t btn_rise;
   pin_vec_t unused_pin_nxt;
   logic     multi_q, multi_d;

   for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
      debounce_cell #(
         .CYCLES (DEBOUNCE_CYCLES),
         .MODE   (EDGE_RISE)
      ) u_cell (
         .clock     (clock),
         .reset_n   (reset_n),
         .raw       (btn_raw[i]),
         .level     (btn_level[i]),
         .level_nxt (btn_nxt[i]),
         .pulse     (btn_rise[i])
      );
   end

   for (genvar i = 0; i < int'(N_PIN); i++) begin : g_pin
      debounce_cell #(
         .CYCLES (DEBOUNCE_CYCLES),
         .MODE   (EDGE_ANY)
      ) u_cell (
         .clock     (clock),
         .reset_n   (reset_n),
         .raw       (pins_raw[i]),
         .level     (pins_level[i]),
         .level_nxt (unused_pin_nxt[i]),
         .pulse     (pins_change[i])
      );
   end

   // Built from the next level so the flag moves with btn_level.
   always_comb begin
      multi_d = multi_hot(btn_nxt);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         multi_q <= 1'b0;
      end else begin
         multi_q <= multi_d;
      end
   end

   assign btn_multi = multi_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam int unsigned RW =
      $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   logic [N_BTN-1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
   btn_vec_t                 rpt_first_q, rpt_first_d;
   btn_vec_t                 rpt_fire_q, rpt_fire_d;

   // Count cycles since the last press of a held button. The first
   // interval is the delay, later ones the period. Nothing fires in
   // the cycle the level is about to drop.
   always_comb begin
      for (int i = 0; i < int'(N_BTN); i++) begin
         rpt_cnt_d[i]   = '0;
         rpt_first_d[i] = 1'b1;
         rpt_fire_d[i]  = 1'b0;
         if (btn_level[i] && btn_nxt[i]) begin
            rpt_first_d[i] = rpt_first_q[i];
            if (rpt_cnt_q[i] == (rpt_first_q[i] ?
                                 RW'(REPEAT_DELAY - 1) :
                                 RW'(REPEAT_PERIOD - 1))) begin
               rpt_fire_d[i]  = 1'b1;
               rpt_first_d[i] = 1'b0;
            end else begin
               rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rpt_cnt_q   <= '0;
         rpt_first_q <= '1;
         rpt_fire_q  <= '0;
      end else begin
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_first_q <= rpt_first_d;
         rpt_fire_q  <= rpt_fire_d;
      end
   end

   assign btn_press = btn_rise | rpt_fire_q;
`else
   localparam int unsigned unused_rpt = REPEAT_DELAY + REPEAT_PERIOD;

   assign btn_press = btn_rise;
`endif

endmodule
